// File: rtl/aibcr3aux_osc_freq_mon.sv
// Aux oscillator frequency monitor: counts CP cycles between synchronized reference toggles,
// range-checks each window and qualifies lock. Define AIBCR3AUX_FREQ_MON_STICKY_ERR_EN for a sticky osc_err.
module aibcr3aux_osc_freq_mon #(
  parameter int CNT_W    = 12,
  parameter int LOCK_CNT = 4
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             en,
  input  logic             ref_tgl,
  input  logic [CNT_W-1:0] cnt_lo,
  input  logic [CNT_W-1:0] cnt_hi,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cnt_vld,
  output logic             osc_ok,
  output logic             osc_err,
  output logic [1:0]       mon_st
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_COUNT = 2'b10
  } st_e;

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  st_e              state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_val_q;
  logic [3:0]       run_q;
  logic             ref_prev_q;
  logic             cnt_vld_q;
  logic             ok_q;
  logic             err_q;

  logic             tgl_edge;
  logic             cnt_max;
  logic             in_rng;
  logic [3:0]       run_d;

  always_comb begin
    tgl_edge = ref_tgl ^ ref_prev_q;
    cnt_max  = &cnt_q;
    in_rng   = (cnt_q >= cnt_lo) && (cnt_q <= cnt_hi);
    // run saturates at LOCK_CNT so osc_ok holds through long good stretches
    run_d    = (run_q == LOCK_V) ? run_q : run_q + 4'd1;
  end

`ifndef AIBCR3AUX_FREQ_MON_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cnt_val_q  <= '0;
      run_q      <= '0;
      ref_prev_q <= 1'b0;
      cnt_vld_q  <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ref_prev_q <= ref_tgl;
      cnt_vld_q  <= 1'b0;
`ifdef AIBCR3AUX_FREQ_MON_STICKY_ERR_EN
      if (err_clr) err_q <= 1'b0;
`else
      err_q <= 1'b0;
`endif
      if (!en) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        run_q   <= '0;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_ARM;
          ST_ARM: begin
            if (tgl_edge) begin
              state_q <= ST_COUNT;
              cnt_q   <= CNT_W'(1);
            end
          end
          ST_COUNT: begin
            // an edge on the all-ones cycle closes a normal window, not a timeout
            if (tgl_edge) begin
              cnt_val_q <= cnt_q;
              cnt_vld_q <= 1'b1;
              cnt_q     <= CNT_W'(1);
              if (in_rng) begin
                run_q <= run_d;
                ok_q  <= (run_d == LOCK_V);
              end else begin
                run_q <= '0;
                ok_q  <= 1'b0;
                err_q <= 1'b1;
              end
            end else if (cnt_max) begin
              cnt_val_q <= '1;
              cnt_vld_q <= 1'b1;
              cnt_q     <= '0;
              run_q     <= '0;
              ok_q      <= 1'b0;
              err_q     <= 1'b1;
              state_q   <= ST_ARM;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cnt_val = cnt_val_q;
  assign cnt_vld = cnt_vld_q;
  assign osc_ok  = ok_q;
  assign osc_err = err_q;
  assign mon_st  = state_q;

endmodule

// File: tb/tb_aibcr3aux_osc_freq_mon.sv
// Scoreboard bench for aibcr3aux_osc_freq_mon (CNT_W=8): stimulus queues expected windows,
// a negedge monitor pops and compares on every cnt_vld.
module tb_aibcr3aux_osc_freq_mon;

`ifdef AIBCR3AUX_FREQ_MON_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       CP, CDN, en, ref_tgl, err_clr;
  logic [7:0] cnt_lo, cnt_hi, cnt_val;
  logic       cnt_vld, osc_ok, osc_err;
  logic [1:0] mon_st;

  typedef struct packed {
    logic [7:0] v;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   e_st   = 1'b0;

  aibcr3aux_osc_freq_mon #(.CNT_W(8), .LOCK_CNT(4)) dut (
    .CP(CP), .CDN(CDN), .en(en), .ref_tgl(ref_tgl),
    .cnt_lo(cnt_lo), .cnt_hi(cnt_hi), .err_clr(err_clr),
    .cnt_val(cnt_val), .cnt_vld(cnt_vld), .osc_ok(osc_ok),
    .osc_err(osc_err), .mon_st(mon_st)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  always @(negedge CP) begin
    if (CDN === 1'b1 && cnt_vld === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: cnt_val=%0d ok=%0b err=%0b", cnt_val, osc_ok, osc_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cnt_val !== e.v || osc_ok !== e.ok || osc_err !== e.err) begin
          errors++;
          $display("FAIL window: got cnt_val=%0d ok=%0b err=%0b, want cnt_val=%0d ok=%0b err=%0b",
                   cnt_val, osc_ok, osc_err, e.v, e.ok, e.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int v, input bit ok, input bit bad);
    if (bad) e_st = 1'b1;
    else if (!STICKY) e_st = 1'b0;
    q.push_back('{8'(v), ok, e_st});
  endtask

  task automatic kick(input int n);
    repeat (n) @(negedge CP);
    ref_tgl = ~ref_tgl;
  endtask

  task automatic win(input int n, input int v, input bit ok, input bit bad);
    kick(n);
    push(v, ok, bad);
  endtask

  initial begin
    CDN = 1'b0; en = 1'b0; ref_tgl = 1'b1; err_clr = 1'b0;
    cnt_lo = 8'd90; cnt_hi = 8'd110;
    repeat (3) @(negedge CP);
    chk("rst_mon_st", int'(mon_st), 0);
    chk("rst_cnt_val", int'(cnt_val), 0);
    chk("rst_cnt_vld", int'(cnt_vld), 0);
    chk("rst_osc_ok", int'(osc_ok), 0);
    chk("rst_osc_err", int'(osc_err), 0);
    CDN = 1'b1;
    @(negedge CP);
    en = 1'b1;
    repeat (100) @(negedge CP);
    chk("arm_mon_st", int'(mon_st), 1);
    chk("arm_cnt_val", int'(cnt_val), 0);
    chk("arm_osc_ok", int'(osc_ok), 0);
    chk("arm_osc_err", int'(osc_err), 0);

    // lock after four good windows
    kick(5);
    win(100, 100, 0, 0); win(100, 100, 0, 0); win(100, 100, 0, 0);
    win(100, 100, 1, 0); win(100, 100, 1, 0);

    // one long window, then relock
    win(150, 150, 0, 1);
    win(100, 100, 0, 0); win(100, 100, 0, 0); win(100, 100, 0, 0);
    win(100, 100, 1, 0);

    // err_clr mid-window, then bad window coinciding with err_clr
    repeat (50) @(negedge CP);
    err_clr = 1'b1;
    @(negedge CP);
    err_clr = 1'b0;
    e_st = 1'b0;
    chk("err_clr_mid", int'(osc_err), 0);
    repeat (99) @(negedge CP);
    ref_tgl = ~ref_tgl;
    err_clr = 1'b1;
    push(150, 0, 1);
    @(negedge CP);
    err_clr = 1'b0;
    win(99, 100, 0, 0); win(100, 100, 0, 0); win(100, 100, 0, 0);
    win(100, 100, 1, 0);

    // disable mid-window with a toggle in the same cycle
    repeat (50) @(negedge CP);
    en = 1'b0;
    ref_tgl = ~ref_tgl;
    e_st = 1'b0;
    @(negedge CP);
    chk("dis_mon_st", int'(mon_st), 0);
    chk("dis_osc_ok", int'(osc_ok), 0);
    chk("dis_osc_err", int'(osc_err), 0);
    chk("dis_cnt_vld", int'(cnt_vld), 0);
    repeat (20) @(negedge CP);
    en = 1'b1;
    @(negedge CP);
    chk("reen_mon_st", int'(mon_st), 1);
    kick(10);
    win(100, 100, 0, 0);

    // timeout: no more toggles
    push(255, 0, 1);
    repeat (300) @(negedge CP);
    chk("tmo_mon_st", int'(mon_st), 1);
    chk("tmo_osc_ok", int'(osc_ok), 0);
    chk("tmo_osc_err", int'(osc_err), STICKY ? 1 : 0);

    // edge exactly at all-ones is a normal window
    kick(3);
    win(255, 255, 0, 1);
    @(negedge CP);
    chk("max_edge_mon_st", int'(mon_st), 2);
    win(99, 100, 0, 0);

    // inverted bounds: every window bad
    @(negedge CP);
    en = 1'b0;
    e_st = 1'b0;
    @(negedge CP);
    cnt_lo = 8'd200; cnt_hi = 8'd50; en = 1'b1;
    @(negedge CP);
    chk("inv_mon_st", int'(mon_st), 1);
    kick(5);
    win(100, 100, 0, 1); win(100, 100, 0, 1); win(100, 100, 0, 1);
    win(100, 100, 0, 1); win(100, 100, 0, 1);

    repeat (5) @(negedge CP);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
